// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the SRAM arbiter controller
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        DONE
    } state_t;

    localparam int NBYTES      = 4;
    localparam int SRAM_ADDR_W = 9;

    localparam logic                CEN_OFF  = 1'b1;
    localparam logic [NBYTES-1:0]   GWEN_OFF = 4'hF;
    localparam logic [7:0]          WEN_OFF  = 8'hFF;

endpackage

// File: rtl/sram_arbiter_ctrl_rr_arb2.sv
// rtl/sram_arbiter_ctrl_rr_arb2.sv - two-way round-robin / fixed-priority arbiter
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       fixed_prio,
    input  logic       advance,
    output logic [1:0] grant
);

    // Port preferred on the next contention; the port just served loses the next tie.
    logic prefer_p1;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (prefer_p1 && !fixed_prio) ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prefer_p1 <= 1'b0;
        end else if (advance && (grant != 2'b00)) begin
            prefer_p1 <= grant[0];
        end
    end

endmodule

// File: rtl/sram_arbiter_ctrl.sv
// rtl/sram_arbiter_ctrl.sv - two-port arbiter sequencing four 512x8 SRAM macros as 512x32
module sram_arbiter_ctrl
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W     = SRAM_ADDR_W,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [NBYTES-1:0]     p0_be,
    input  logic [ADDR_W-1:0]     p0_addr,
    input  logic [8*NBYTES-1:0]   p0_wdata,
    output logic                  p0_ack,
    output logic [8*NBYTES-1:0]   p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [NBYTES-1:0]     p1_be,
    input  logic [ADDR_W-1:0]     p1_addr,
    input  logic [8*NBYTES-1:0]   p1_wdata,
    output logic                  p1_ack,
    output logic [8*NBYTES-1:0]   p1_rdata,
    output logic                  sram_CEN,
    output logic [NBYTES-1:0]     sram_GWEN,
    output logic [7:0]            sram_WEN,
    output logic [ADDR_W-1:0]     sram_A,
    output logic [8*NBYTES-1:0]   sram_D,
    input  logic [8*NBYTES-1:0]   sram_Q,
    output logic                  busy
);

    state_t                 state;
    logic                   winner;
    logic                   cur_we;
    logic [1:0]             grant;
    logic                   sel_we;
    logic [NBYTES-1:0]      sel_be;
    logic [ADDR_W-1:0]      sel_addr;
    logic [8*NBYTES-1:0]    sel_wdata;

    rr_arb2 u_arb (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .req        ({p1_req, p0_req}),
        .fixed_prio (FIXED_PRIO),
        .advance    (state == IDLE),
        .grant      (grant)
    );

    always_comb begin
        if (grant[1]) begin
            sel_we    = p1_we;
            sel_be    = p1_be;
            sel_addr  = p1_addr;
            sel_wdata = p1_wdata;
        end else begin
            sel_we    = p0_we;
            sel_be    = p0_be;
            sel_addr  = p0_addr;
            sel_wdata = p0_wdata;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            winner    <= 1'b0;
            cur_we    <= 1'b0;
            sram_CEN  <= CEN_OFF;
            sram_GWEN <= GWEN_OFF;
            sram_WEN  <= WEN_OFF;
            sram_A    <= '0;
            sram_D    <= '0;
            p0_ack    <= 1'b0;
            p1_ack    <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        winner   <= grant[1];
                        cur_we   <= sel_we;
                        sram_CEN <= 1'b0;
                        sram_A   <= sel_addr;
                        sram_D   <= sel_wdata;
                        // be=0 writes still run the write sequence, but GWEN stays all-off.
                        sram_GWEN <= sel_we ? ~sel_be : GWEN_OFF;
                        sram_WEN  <= sel_we ? 8'h00   : WEN_OFF;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    sram_CEN  <= CEN_OFF;
                    sram_GWEN <= GWEN_OFF;
                    sram_WEN  <= WEN_OFF;
                    if (cur_we) begin
                        p0_ack <= ~winner;
                        p1_ack <= winner;
                        state  <= DONE;
                    end else begin
                        state  <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (winner) begin
                        p1_rdata <= sram_Q;
                        p1_ack   <= 1'b1;
                    end else begin
                        p0_rdata <= sram_Q;
                        p0_ack   <= 1'b1;
                    end
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// tb/tb_sram_arbiter_ctrl.sv - self-checking bench for sram_arbiter_ctrl with behavioural macros
module tb_sram_arbiter_ctrl;

    logic        clk;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [3:0]  p0_be, p1_be;
    logic [8:0]  p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;

    logic        a_p0_ack, a_p1_ack, a_cen, a_busy;
    logic [31:0] a_p0_rdata, a_p1_rdata, a_d, a_q;
    logic [3:0]  a_gwen;
    logic [7:0]  a_wen;
    logic [8:0]  a_addr;

    logic        b_p0_ack, b_p1_ack, b_cen, b_busy;
    logic [31:0] b_p0_rdata, b_p1_rdata, b_d, b_q;
    logic [3:0]  b_gwen;
    logic [7:0]  b_wen;
    logic [8:0]  b_addr;

    logic [31:0] mem_a [512];
    logic [31:0] mem_b [512];
    logic [31:0] ref_mem [512];

    typedef struct {
        int          port;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    sram_arbiter_ctrl #(.ADDR_W(9), .FIXED_PRIO(1'b0)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_be(p0_be), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(a_p0_ack), .p0_rdata(a_p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_be(p1_be), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(a_p1_ack), .p1_rdata(a_p1_rdata),
        .sram_CEN(a_cen), .sram_GWEN(a_gwen), .sram_WEN(a_wen), .sram_A(a_addr),
        .sram_D(a_d), .sram_Q(a_q), .busy(a_busy)
    );

    sram_arbiter_ctrl #(.ADDR_W(9), .FIXED_PRIO(1'b1)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_be(p0_be), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(b_p0_ack), .p0_rdata(b_p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_be(p1_be), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(b_p1_ack), .p1_rdata(b_p1_rdata),
        .sram_CEN(b_cen), .sram_GWEN(b_gwen), .sram_WEN(b_wen), .sram_A(b_addr),
        .sram_D(b_d), .sram_Q(b_q), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 4x 512x8 macros: byte i written when GWEN[i] low, read otherwise.
    always @(posedge clk) begin
        if (!a_cen) begin
            for (int i = 0; i < 4; i++) begin
                if (!a_gwen[i])
                    mem_a[a_addr][8*i +: 8] = (a_d[8*i +: 8] & ~a_wen) | (mem_a[a_addr][8*i +: 8] & a_wen);
                else
                    a_q[8*i +: 8] <= mem_a[a_addr][8*i +: 8];
            end
        end
    end

    always @(posedge clk) begin
        if (!b_cen) begin
            for (int i = 0; i < 4; i++) begin
                if (!b_gwen[i])
                    mem_b[b_addr][8*i +: 8] = (b_d[8*i +: 8] & ~b_wen) | (mem_b[b_addr][8*i +: 8] & b_wen);
                else
                    b_q[8*i +: 8] <= mem_b[b_addr][8*i +: 8];
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        p0_req = 1'b0;
        p1_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_access(input int port, input logic we, input logic [3:0] be,
                              input logic [8:0] addr, input logic [31:0] wd,
                              output int lat, output int cen_cycles,
                              output logic [3:0] gwen_and, output logic [31:0] rd);
        if (port == 0) begin
            p0_we = we; p0_be = be; p0_addr = addr; p0_wdata = wd; p0_req = 1'b1;
        end else begin
            p1_we = we; p1_be = be; p1_addr = addr; p1_wdata = wd; p1_req = 1'b1;
        end
        if (we) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) ref_mem[addr][8*i +: 8] = wd[8*i +: 8];
        end
        lat = -1;
        cen_cycles = 0;
        gwen_and = 4'hF;
        rd = '0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (!a_cen) cen_cycles++;
            gwen_and &= a_gwen;
            if ((port == 0 && a_p0_ack) || (port == 1 && a_p1_ack)) begin
                lat = c;
                rd = (port == 0) ? a_p0_rdata : a_p1_rdata;
                break;
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({a_cen, a_gwen, a_wen, a_addr, a_d} !== {1'b1, 4'hF, 8'hFF, 9'h000, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_sram: got cen=%b gwen=%h wen=%h a=%h d=%h, want 1 f ff 000 00000000",
                     a_cen, a_gwen, a_wen, a_addr, a_d);
        end
        n_checks++;
        if ({a_p0_ack, a_p1_ack, a_busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ack_busy: got %b want 000", {a_p0_ack, a_p1_ack, a_busy});
        end
        n_checks++;
        if ({a_p0_rdata, a_p1_rdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h want 0", {a_p0_rdata, a_p1_rdata});
        end
    endtask

    task automatic test_write_read();
        int lat, cen_cycles;
        logic [3:0] g;
        logic [31:0] rd;
        exp_t e;
        run_access(0, 1'b1, 4'hF, 9'h005, 32'hDEADBEEF, lat, cen_cycles, g, rd);
        n_checks++;
        if (lat !== 2 || cen_cycles !== 1 || g !== 4'h0) begin
            n_fail++;
            $display("FAIL wr_basic: got lat=%0d cen_cycles=%0d gwen=%h want 2 1 0", lat, cen_cycles, g);
        end
        sb.push_back('{0, ref_mem[9'h005]});
        run_access(0, 1'b0, 4'hF, 9'h005, 32'h0, lat, cen_cycles, g, rd);
        n_checks++;
        if (lat !== 3 || cen_cycles !== 1 || g !== 4'hF) begin
            n_fail++;
            $display("FAIL rd_basic_timing: got lat=%0d cen_cycles=%0d gwen=%h want 3 1 f", lat, cen_cycles, g);
        end
        e = sb.pop_front();
        n_checks++;
        if (rd !== e.data) begin
            n_fail++;
            $display("FAIL rd_basic_data: got %h want %h", rd, e.data);
        end
    endtask

    task automatic test_partial_write();
        int lat, cen_cycles;
        logic [3:0] g;
        logic [31:0] rd;
        exp_t e;
        run_access(0, 1'b1, 4'hF, 9'h1FF, 32'hAAAAAAAA, lat, cen_cycles, g, rd);
        run_access(1, 1'b1, 4'b0101, 9'h1FF, 32'h11223344, lat, cen_cycles, g, rd);
        n_checks++;
        if (lat !== 2 || g !== 4'b1010) begin
            n_fail++;
            $display("FAIL partial_wr: got lat=%0d gwen=%b want 2 1010", lat, g);
        end
        sb.push_back('{1, ref_mem[9'h1FF]});
        run_access(1, 1'b0, 4'hF, 9'h1FF, 32'h0, lat, cen_cycles, g, rd);
        e = sb.pop_front();
        n_checks++;
        if (rd !== e.data || rd !== 32'hAA22AA44) begin
            n_fail++;
            $display("FAIL partial_rd: got %h want %h", rd, e.data);
        end
        sb.push_back('{0, ref_mem[9'h000]});
        run_access(0, 1'b0, 4'hF, 9'h000, 32'h0, lat, cen_cycles, g, rd);
        e = sb.pop_front();
        n_checks++;
        if (rd !== e.data) begin
            n_fail++;
            $display("FAIL addr0_untouched: got %h want %h", rd, e.data);
        end
    endtask

    task automatic test_be_zero();
        int lat, cen_cycles;
        logic [3:0] g;
        logic [31:0] rd;
        exp_t e;
        run_access(0, 1'b1, 4'hF, 9'h010, 32'h12345678, lat, cen_cycles, g, rd);
        run_access(0, 1'b1, 4'h0, 9'h010, 32'hFFFFFFFF, lat, cen_cycles, g, rd);
        n_checks++;
        if (lat !== 2 || cen_cycles !== 1 || g !== 4'hF) begin
            n_fail++;
            $display("FAIL be0_wr: got lat=%0d cen_cycles=%0d gwen=%h want 2 1 f", lat, cen_cycles, g);
        end
        sb.push_back('{0, ref_mem[9'h010]});
        run_access(0, 1'b0, 4'hF, 9'h010, 32'h0, lat, cen_cycles, g, rd);
        e = sb.pop_front();
        n_checks++;
        if (rd !== e.data) begin
            n_fail++;
            $display("FAIL be0_rd: got %h want %h", rd, e.data);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] last0, last1;
        logic prev0, prev1;
        int bad_port, bad_data, bad_other, bad_width;
        do_reset();
        sb.delete();
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) sb.push_back('{0, ref_mem[9'h005]});
            else            sb.push_back('{1, ref_mem[9'h1FF]});
        end
        last0 = '0; last1 = '0; prev0 = 1'b0; prev1 = 1'b0;
        bad_port = 0; bad_data = 0; bad_other = 0; bad_width = 0;
        p0_we = 1'b0; p0_be = 4'hF; p0_addr = 9'h005;
        p1_we = 1'b0; p1_be = 4'hF; p1_addr = 9'h1FF;
        p0_req = 1'b1; p1_req = 1'b1;
        for (int c = 0; c < 60 && sb.size() != 0; c++) begin
            @(posedge clk);
            @(negedge clk);
            if ((a_p0_ack && prev0) || (a_p1_ack && prev1) || (a_p0_ack && a_p1_ack)) bad_width++;
            if (a_p0_ack || a_p1_ack) begin
                e = sb.pop_front();
                if (e.port != (a_p1_ack ? 1 : 0)) bad_port++;
                if (a_p0_ack) begin
                    if (a_p0_rdata !== e.data) bad_data++;
                    if (a_p1_rdata !== last1) bad_other++;
                    last0 = a_p0_rdata;
                end else begin
                    if (a_p1_rdata !== e.data) bad_data++;
                    if (a_p0_rdata !== last0) bad_other++;
                    last1 = a_p1_rdata;
                end
            end
            prev0 = a_p0_ack;
            prev1 = a_p1_ack;
        end
        p0_req = 1'b0; p1_req = 1'b0;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_complete: got %0d acks missing want 0", sb.size());
        end
        n_checks++;
        if (bad_port != 0) begin
            n_fail++;
            $display("FAIL b2b_alternate: got %0d out-of-order grants want 0", bad_port);
        end
        n_checks++;
        if (bad_data != 0 || bad_other != 0) begin
            n_fail++;
            $display("FAIL b2b_rdata: got %0d bad data, %0d disturbed other rdata, want 0 0", bad_data, bad_other);
        end
        n_checks++;
        if (bad_width != 0) begin
            n_fail++;
            $display("FAIL b2b_ack_width: got %0d wide/double acks want 0", bad_width);
        end
        sb.delete();
    endtask

    task automatic test_reset_in_capture();
        int lat, cen_cycles, ack_seen;
        logic [3:0] g;
        logic [31:0] rd;
        exp_t e;
        do_reset();
        sb.push_back('{1, ref_mem[9'h005]});
        run_access(1, 1'b0, 4'hF, 9'h005, 32'h0, lat, cen_cycles, g, rd);
        e = sb.pop_front();
        n_checks++;
        if (rd !== e.data) begin
            n_fail++;
            $display("FAIL p1_rd_before_rst: got %h want %h", rd, e.data);
        end
        p1_we = 1'b0; p1_addr = 9'h1FF; p1_req = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({a_busy, a_cen, a_p1_ack, a_p1_rdata} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL rst_capture: got busy=%b cen=%b ack=%b rdata=%h want 0 1 0 00000000",
                     a_busy, a_cen, a_p1_ack, a_p1_rdata);
        end
        rst = 1'b0;
        p1_req = 1'b0;
        ack_seen = 0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            if (a_p1_ack) ack_seen++;
        end
        n_checks++;
        if (ack_seen != 0) begin
            n_fail++;
            $display("FAIL rst_no_ack: got %0d acks want 0", ack_seen);
        end
    endtask

    task automatic test_fixed_prio();
        int p0_acks, p1_early, wait_cycles;
        do_reset();
        p0_acks = 0; p1_early = 0; wait_cycles = -1;
        p0_we = 1'b0; p0_be = 4'hF; p0_addr = 9'h005;
        p1_we = 1'b0; p1_be = 4'hF; p1_addr = 9'h1FF;
        p0_req = 1'b1; p1_req = 1'b1;
        for (int c = 0; c < 40 && p0_acks < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (b_p1_ack) p1_early++;
            if (b_p0_ack) p0_acks++;
        end
        p0_req = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (b_p1_ack) begin
                wait_cycles = c;
                break;
            end
        end
        p1_req = 1'b0;
        n_checks++;
        if (p0_acks != 4 || p1_early != 0) begin
            n_fail++;
            $display("FAIL fixed_starve: got p0_acks=%0d p1_acks=%0d want 4 0", p0_acks, p1_early);
        end
        n_checks++;
        if (wait_cycles != 4) begin
            n_fail++;
            $display("FAIL fixed_p1_after_drop: got %0d cycles want 4", wait_cycles);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
            ref_mem[i] = '0;
        end
        a_q = '0; b_q = '0;
        rst = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_be = '0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_be = '0; p1_addr = '0; p1_wdata = '0;
        test_reset();
        test_write_read();
        test_partial_write();
        test_be_zero();
        test_back_to_back();
        test_reset_in_capture();
        test_fixed_prio();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
